// File: rtl/trig_burst_sequencer.sv
// Burst sequencer for the clock/trigger routing block: latches a routing mode, waits a settle
// interval, then issues N trigger pulses of programmed width and gap. Define TRIG_CONT_EN to make
// burst_count==0 mean continuous pulsing until abort.
module trig_burst_sequencer #(
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic             fastclk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode_in,
  input  logic [CNT_W-1:0] burst_count,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] pulse_gap,
  input  logic             abort,
  output logic [1:0]       switches_out,
  output logic             trigger_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] pulses_issued
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SettleLoad = SW'(SETTLE_CYC - 1);
`ifdef TRIG_CONT_EN
  localparam bit ContEn = 1'b1;
`else
  localparam bit ContEn = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CONFIG, PULSE_HI, PULSE_LO, DONE} state_t;

  state_t           state_q;
  logic [1:0]       switches_q;
  logic             trigger_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic [CNT_W-1:0] pulses_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] gap_q;
  logic [SW-1:0]    settle_q;
  logic [CNT_W-1:0] phase_q;

  // Phase timers are loaded with length-1 and count down to zero; a zero length behaves as one.
  logic [CNT_W-1:0] widthLoad;
  logic [CNT_W-1:0] gapLoad;
  logic             contMode;
  logic             morePulses;
  logic             activeState;

  assign widthLoad   = (width_q == '0) ? '0 : width_q - CNT_W'(1);
  assign gapLoad     = (gap_q == '0) ? '0 : gap_q - CNT_W'(1);
  assign contMode    = ContEn && (count_q == '0);
  assign morePulses  = contMode || (pulses_q < count_q);
  assign activeState = (state_q == CONFIG) || (state_q == PULSE_HI) || (state_q == PULSE_LO);

  always_ff @(posedge fastclk) begin
    if (reset) begin
      state_q    <= IDLE;
      switches_q <= 2'b00;
      trigger_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      pulses_q   <= '0;
      count_q    <= '0;
      width_q    <= '0;
      gap_q      <= '0;
      settle_q   <= '0;
      phase_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && activeState) begin
        state_q   <= DONE;
        trigger_q <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b0 | 1'b1;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              count_q    <= burst_count;
              width_q    <= pulse_width;
              gap_q      <= pulse_gap;
              switches_q <= mode_in;
              busy_q     <= 1'b1;
              aborted_q  <= 1'b0;
              pulses_q   <= '0;
              settle_q   <= SettleLoad;
              state_q    <= CONFIG;
            end
          end
          CONFIG: begin
            if (settle_q != '0) begin
              settle_q <= settle_q - SW'(1);
            end else if ((count_q != '0) || ContEn) begin
              state_q   <= PULSE_HI;
              trigger_q <= 1'b1;
              pulses_q  <= pulses_q + CNT_W'(1);
              phase_q   <= widthLoad;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          PULSE_HI: begin
            if (phase_q != '0) begin
              phase_q <= phase_q - CNT_W'(1);
            end else begin
              state_q   <= PULSE_LO;
              trigger_q <= 1'b0;
              phase_q   <= gapLoad;
            end
          end
          PULSE_LO: begin
            if (phase_q != '0) begin
              phase_q <= phase_q - CNT_W'(1);
            end else if (morePulses) begin
              state_q   <= PULSE_HI;
              trigger_q <= 1'b1;
              pulses_q  <= pulses_q + CNT_W'(1);
              phase_q   <= widthLoad;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign switches_out  = switches_q;
  assign trigger_out   = trigger_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign pulses_issued = pulses_q;

endmodule
